// File: rtl/regfile_dump_ctrl_if.sv
// regfile_dump_ctrl_if: valid/ready word stream carrying a register index and its captured value
interface regfile_dump_ctrl_if #(parameter int ADDR_W = 5, parameter int DATA_W = 32);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  modport master(output valid, addr, data, input ready);
  modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: snapshots a register-file address range onto a valid/ready stream with a running XOR checksum
module regfile_dump_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [ADDR_W-1:0]   i_first_addr,
  input  logic [ADDR_W-1:0]   i_last_addr,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [DATA_W-1:0]   i_rd_data,
  output logic                o_freeze,
  output logic                o_busy,
  output logic                o_done,
  output logic [DATA_W-1:0]   o_checksum,
  regfile_dump_ctrl_if.master o_stream
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cur, r_end, r_out_addr;
  logic [DATA_W-1:0] r_out_data, r_checksum;
  logic              r_valid;
  logic              w_accept;
  assign w_accept         = r_valid && o_stream.ready;
  // The current address only moves on entry to READ, so it doubles as the held read address.
  assign o_rd_addr        = r_cur;
  assign o_stream.valid   = r_valid;
  assign o_stream.addr    = r_out_addr;
  assign o_stream.data    = r_out_data;
  assign o_checksum       = r_checksum;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Next state: abort beats the handshake; start only counts in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = i_start ? READ : IDLE;
      READ: w_next = i_abort ? IDLE : SEND;
      SEND: w_next = i_abort ? IDLE : !w_accept ? SEND : (r_cur == r_end) ? DONE : READ;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Outputs decoded from state
  always_comb begin
    o_busy   = (r_state == READ) || (r_state == SEND);
    o_freeze = o_busy;
    o_done   = (r_state == DONE);
  end
  // Datapath: range capture, word capture, handshake retirement and checksum accumulation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cur      <= '0;
      r_end      <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_checksum <= '0;
      r_valid    <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_cur      <= i_first_addr;
      r_end      <= i_last_addr;
      r_checksum <= '0;
    end else if (r_state == READ && !i_abort) begin
      r_out_data <= i_rd_data;
      r_out_addr <= r_cur;
      r_valid    <= 1'b1;
    end else if (r_state == SEND && i_abort) begin
      r_valid    <= 1'b0;
    end else if (r_state == SEND && w_accept) begin
      r_checksum <= r_checksum ^ r_out_data;
      r_valid    <= 1'b0;
      if (r_cur != r_end) r_cur <= r_cur + 1'b1;
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: randomized dumps against a range/XOR reference model of the register-file snapshot
module tb_regfile_dump_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [4:0]  first_addr, last_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        freeze, busy, done;
  logic [31:0] checksum;
  logic [31:0] regs [32];
  int          checks = 0;
  int          failures = 0;

  regfile_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) s ();

  regfile_dump_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_first_addr(first_addr), .i_last_addr(last_addr),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_freeze(freeze), .o_busy(busy), .o_done(done),
    .o_checksum(checksum), .o_stream(s)
  );

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    regs[0] = 32'h0;
  endtask

  // stall < 0: ready held low 5 cycles per word; otherwise ready low with stall% probability
  task automatic run_dump(input int f, input int l, input int stall, input int abort_after, input bit with_abort);
    int          n;
    int          idx;
    int          cycles;
    int          hold;
    bit          stalled;
    logic [4:0]  ea;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic [31:0] ex;
    n = ((l - f) & 31) + 1;
    idx = 0; cycles = 0; hold = 0; stalled = 0; ex = 0; sa = 0; sd = 0;
    @(negedge clk);
    start = 1'b1; abort = with_abort; first_addr = 5'(f); last_addr = 5'(l);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("lat_busy", {31'b0, busy}, 32'd1);
    chk("lat_valid", {31'b0, s.valid}, 32'd0);
    chk("rd_first", {27'b0, rd_addr}, {27'b0, 5'(f)});
    while (idx < n) begin
      if (cycles >= 3000) begin
        chk("timeout", 32'd1, 32'd0);
        break;
      end
      if (idx == abort_after) begin
        abort = 1'b1; start = 1'b0; s.ready = 1'($urandom_range(1));
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", {31'b0, s.valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_freeze", {31'b0, freeze}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_csum", checksum, ex);
        @(negedge clk);
        chk("abort_nodone", {31'b0, done}, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        s.ready = 1'b0;
        return;
      end
      if (stalled) begin
        chk("stall_valid", {31'b0, s.valid}, 32'd1);
        chk("stall_addr", {27'b0, s.addr}, {27'b0, sa});
        chk("stall_data", s.data, sd);
      end
      chk("freeze", {31'b0, freeze}, 32'd1);
      chk("done_low", {31'b0, done}, 32'd0);
      if (stall < 0) begin
        s.ready = (hold >= 5);
        if (s.valid) hold = s.ready ? 0 : hold + 1;
      end else begin
        s.ready = ($urandom_range(99) >= stall);
      end
      start = ($urandom_range(3) == 0);
      stalled = s.valid && !s.ready;
      sa = s.addr; sd = s.data;
      if (s.valid && s.ready) begin
        ea = 5'(f + idx);
        chk("word_addr", {27'b0, s.addr}, {27'b0, ea});
        chk("word_data", s.data, regs[ea]);
        ex ^= regs[ea];
        idx++;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0; s.ready = 1'b0;
    chk("word_count", idx, n);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_valid", {31'b0, s.valid}, 32'd0);
    chk("done_csum", checksum, ex);
    @(negedge clk);
    chk("done_single", {31'b0, done}, 32'd0);
    chk("csum_hold", checksum, ex);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdaddr"}, {27'b0, rd_addr}, 32'd0);
    chk({tag, "_oaddr"}, {27'b0, s.addr}, 32'd0);
    chk({tag, "_odata"}, s.data, 32'd0);
    chk({tag, "_csum"}, checksum, 32'd0);
    chk({tag, "_ctl"}, {28'b0, s.valid, freeze, busy, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; first_addr = '0; last_addr = '0; s.ready = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'(k * 3);
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_dump(0, 31, 0, -1, 1'b0);
    fill_random();
    run_dump(4, 6, -1, -1, 1'b0);
    run_dump(30, 1, 50, -1, 1'b0);
    regs[7] = 32'hDEADBEEF;
    run_dump(7, 7, 30, -1, 1'b0);
    chk("single_csum", checksum, 32'hDEADBEEF);
    run_dump(10, 20, 20, 2, 1'b0);
    run_dump(12, 15, 40, -1, 1'b1);
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_dump(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(70)), -1, 1'b0);
    end
    @(negedge clk);
    start = 1'b1; first_addr = 5'd3; last_addr = 5'd9; s.ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, s.valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_dump(3, 9, 25, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
